// File: rtl/fetch_queue_if.sv
// fetch_queue_if: bus between the fetch stage, the fetch queue and decode.
//   start_i       pipeline run enable (low holds the queue empty)
//   flush_i       redirect; discards every queued entry
//   fetch_valid_i pc_i/instr_i carry a fetched instruction this cycle
//   pc_i, instr_i fetched PC and instruction word
//   stall_o       queue full; stalls the PC register
//   id_ready_i    decode accepts the head entry this cycle
//   id_valid_o    head entry present
//   id_pc_o       PC of the head entry (0 when empty)
//   id_instr_o    instruction of the head entry (0 when empty)
//   count_o       number of stored entries
// slave = queue side, master = surrounding pipeline / testbench side.
interface fetch_queue_if #(
   parameter int CW = 3
);
   logic          start_i;
   logic          flush_i;
   logic          fetch_valid_i;
   logic [31:0]   pc_i;
   logic [31:0]   instr_i;
   logic          stall_o;
   logic          id_ready_i;
   logic          id_valid_o;
   logic [31:0]   id_pc_o;
   logic [31:0]   id_instr_o;
   logic [CW-1:0] count_o;

   modport slave (
      input  start_i, flush_i, fetch_valid_i, pc_i, instr_i, id_ready_i,
      output stall_o, id_valid_o, id_pc_o, id_instr_o, count_o
   );

   modport master (
      output start_i, flush_i, fetch_valid_i, pc_i, instr_i, id_ready_i,
      input  stall_o, id_valid_o, id_pc_o, id_instr_o, count_o
   );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: circular buffer of {PC, instruction} pairs between fetch and
// decode. No empty bypass (a push shows on id_* one cycle later) and no
// full pass-through (a push while full is dropped even if decode pops).
// Ports:
//   clk_i  sole clock, rising edge
//   rst_i  asynchronous active-high reset of pointers and count
//   bus    fetch_queue_if.slave, see the interface file for signal list
module fetch_queue #(
   parameter int DEPTH = 4,
   parameter int CW    = 3
) (
   input logic          clk_i,
   input logic          rst_i,
   fetch_queue_if.slave bus
);
   localparam int AW = $clog2(DEPTH);

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [31:0]   mem_pc    [DEPTH];
   logic [31:0]   mem_instr [DEPTH];

   logic full;
   logic not_empty;
   logic run;
   logic push;
   logic pop;

   assign full      = (count == CW'(DEPTH));
   assign not_empty = (count != '0);
   // flush or a stopped pipeline wins over any push/pop this cycle
   assign run       = bus.start_i && !bus.flush_i;
   assign push      = run && bus.fetch_valid_i && !full;
   assign pop       = run && not_empty && bus.id_ready_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (!run) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)
            count <= count + CW'(1);
         else if (pop && !push)
            count <= count - CW'(1);
      end
   end

   // storage is not reset; pointers and count alone define what is valid
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_pc[wr_ptr]    <= bus.pc_i;
         mem_instr[wr_ptr] <= bus.instr_i;
      end
   end

   // while stopped the queue is treated as flushed, so never report full
   assign bus.stall_o    = full && bus.start_i;
   assign bus.id_valid_o = not_empty;
   assign bus.id_pc_o    = not_empty ? mem_pc[rd_ptr]    : 32'h0;
   assign bus.id_instr_o = not_empty ? mem_instr[rd_ptr] : 32'h0;
   assign bus.count_o    = count;
endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
   localparam int DEPTH = 4;
   localparam int CW    = 3;

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;

   fetch_queue_if #(.CW(CW)) bus ();

   fetch_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus)
   );

   always #5 clk_i = ~clk_i;

   int n_tests = 0;
   int n_fail  = 0;
   logic [63:0] sb [$];   // {pc, instr} the queue should hold, head first

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // monitor: every cycle between edges compare visible state with the model,
   // and retire the head whenever decode takes it
   always @(negedge clk_i) begin
      logic [63:0] head;
      check("count", 32'(bus.count_o), 32'(sb.size()));
      check("valid", 32'(bus.id_valid_o), 32'(sb.size() != 0));
      check("stall", 32'(bus.stall_o), 32'(sb.size() == DEPTH && bus.start_i));
      head = (sb.size() != 0) ? sb[0] : 64'h0;
      check("id_pc", bus.id_pc_o, head[63:32]);
      check("id_instr", bus.id_instr_o, head[31:0]);
      if (!rst_i && bus.id_valid_o && bus.id_ready_i && bus.start_i && !bus.flush_i) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL pop_underflow: DUT popped with empty model at %0t", $time);
         end else begin
            void'(sb.pop_front());
         end
      end
   end

   // drive one cycle; the model is updated at the edge from the pre-edge size
   task automatic drive(input logic fv, input logic [31:0] pc, input logic [31:0] ins,
                        input logic rdy, input logic st, input logic fl);
      logic acc;
      bus.fetch_valid_i = fv;
      bus.pc_i          = pc;
      bus.instr_i       = ins;
      bus.id_ready_i    = rdy;
      bus.start_i       = st;
      bus.flush_i       = fl;
      acc = fv && st && !fl && (sb.size() < DEPTH);
      @(posedge clk_i);
      if (fl || !st)
         sb.delete();
      else if (acc)
         sb.push_back({pc, ins});
      #1;
   endtask

   task automatic drain();
      for (int i = 0; i < DEPTH + 2; i++)
         drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
   endtask

   initial begin
      bus.fetch_valid_i = 1'b0;
      bus.pc_i          = '0;
      bus.instr_i       = '0;
      bus.id_ready_i    = 1'b0;
      bus.start_i       = 1'b0;
      bus.flush_i       = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      check("rst_count", 32'(bus.count_o), 32'h0);
      check("rst_valid", 32'(bus.id_valid_o), 32'h0);
      rst_i = 1'b0;

      // basic flow, decode always ready
      for (int i = 0; i < 3; i++)
         drive(1'b1, 32'(i * 4), 32'hA000_0000 + 32'(i), 1'b1, 1'b1, 1'b0);
      check("basic_count", 32'(bus.count_o), 32'h1);
      check("basic_last_pc", bus.id_pc_o, 32'h8);
      drain();

      // fill to full, fifth push dropped
      for (int i = 0; i < 5; i++)
         drive(1'b1, 32'h10 + 32'(i * 4), 32'hB000_0000 + 32'(i), 1'b0, 1'b1, 1'b0);
      check("full_stall", 32'(bus.stall_o), 32'h1);
      check("full_count", 32'(bus.count_o), 32'h4);
      check("full_head", bus.id_pc_o, 32'h10);

      // full with push and pop together: push dropped
      drive(1'b1, 32'h999, 32'h999, 1'b1, 1'b1, 1'b0);
      check("fullpp_count", 32'(bus.count_o), 32'h3);
      check("fullpp_stall", 32'(bus.stall_o), 32'h0);
      drain();

      // wrap-around with pops lagging by two
      for (int i = 0; i < 10; i++)
         drive(1'b1, 32'h100 + 32'(i * 4), 32'hC000_0000 + 32'(i), i >= 2, 1'b1, 1'b0);
      drain();

      // flush with a concurrent push
      for (int i = 0; i < 3; i++)
         drive(1'b1, 32'h200 + 32'(i * 4), 32'hD000_0000 + 32'(i), 1'b0, 1'b1, 1'b0);
      drive(1'b1, 32'h300, 32'hDEAD_0000, 1'b0, 1'b1, 1'b1);
      check("flush_count", 32'(bus.count_o), 32'h0);
      check("flush_valid", 32'(bus.id_valid_o), 32'h0);
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);

      // asynchronous reset mid-cycle with two entries stored
      for (int i = 0; i < 2; i++)
         drive(1'b1, 32'h400 + 32'(i * 4), 32'hE000_0000 + 32'(i), 1'b0, 1'b1, 1'b0);
      bus.fetch_valid_i = 1'b0;
      #1 rst_i = 1'b1;
      #1;
      check("arst_valid", 32'(bus.id_valid_o), 32'h0);
      check("arst_pc", bus.id_pc_o, 32'h0);
      check("arst_count", 32'(bus.count_o), 32'h0);
      sb.delete();
      @(negedge clk_i);
      #1 rst_i = 1'b0;
      @(posedge clk_i);
      #1;
      drive(1'b1, 32'h500, 32'hF000_0000, 1'b1, 1'b1, 1'b0);
      check("resume_pc", bus.id_pc_o, 32'h500);
      drain();

      // randomized traffic
      for (int i = 0; i < 600; i++)
         drive($urandom_range(0, 3) != 0, $urandom, $urandom,
               $urandom_range(0, 1) == 1, $urandom_range(0, 19) != 0,
               $urandom_range(0, 24) == 0);
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, limit 200000 reached");
      $fatal(1);
   end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL provide parameter DEPTH, default 4, number of PC/instruction entries (power of two, 2..16).
REQ-002 SHALL provide parameter CW, default 3, count width, equal to log2(DEPTH)+1.
REQ-003 SHALL provide port clk_i  input  1  sole clock, all state on rising edge.
REQ-004 SHALL provide port rst_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL provide port start_i  input  1  pipeline run enable; low holds queue empty.
REQ-006 SHALL provide port flush_i  input  1  branch/jump redirect; discards all entries.
REQ-007 SHALL provide port fetch_valid_i  input  1  pc_i/instr_i carry a fetched instruction this cycle.
REQ-008 SHALL provide port pc_i  input  32  PC of fetched instruction (from PC register output).
REQ-009 SHALL provide port instr_i  input  32  instruction word from instruction memory.
REQ-010 SHALL provide port stall_o  output  1  queue full; drives the PC stall input.
REQ-011 SHALL provide port id_ready_i  input  1  decode stage accepts the head entry this cycle.
REQ-012 SHALL provide port id_valid_o  output  1  head entry present.
REQ-013 SHALL provide port id_pc_o  output  32  PC of head entry.
REQ-014 SHALL provide port id_instr_o  output  32  instruction of head entry.
REQ-015 SHALL provide port count_o  output  CW  number of stored entries, 0..DEPTH.

Function
REQ-016 SHALL store entries in a circular buffer with wr_ptr, rd_ptr (log2(DEPTH) bits, wrap DEPTH-1 -> 0) and a registered count.
REQ-017 SHALL accept a push at a clock edge iff fetch_valid_i=1, start_i=1, flush_i=0 and count<DEPTH; a push writes {pc_i, instr_i} at wr_ptr and increments wr_ptr.
REQ-018 SHALL perform a pop at a clock edge iff id_valid_o=1, id_ready_i=1, start_i=1 and flush_i=0; a pop increments rd_ptr.
REQ-019 SHALL update count by +1 (push only), -1 (pop only), or 0 (both or neither).
REQ-020 SHALL drop the push when full, even if a pop occurs in the same cycle (no full-pass-through).
REQ-021 SHALL have no empty-bypass: a push into an empty queue is visible on id_* one cycle later.
REQ-022 SHALL drive stall_o = (count==DEPTH) combinationally from registered count only; it SHALL NOT depend on id_ready_i.
REQ-023 SHALL drive id_valid_o = (count!=0); id_pc_o and id_instr_o SHALL show the entry at rd_ptr when id_valid_o=1 and 0 otherwise.
REQ-024 SHALL give flush_i priority over push and pop: at the edge, count, wr_ptr and rd_ptr become 0 and same-cycle push is discarded.
REQ-025 SHALL treat start_i=0 like a flush every cycle; stall_o SHALL be 0 while start_i=0.
REQ-026 SHALL not alter stored data of unpopped entries except by push to its own slot.
REQ-027 SHALL assert count_o = count at all times.

Reset
REQ-028 SHALL, while rst_i=1, asynchronously force count=0, wr_ptr=0, rd_ptr=0, hence stall_o=0, id_valid_o=0, id_pc_o=0, id_instr_o=0, count_o=0.
REQ-029 SHALL, on reset asserted mid-operation, discard all entries immediately; storage contents need not be cleared.
REQ-030 SHALL resume normal operation at the first rising edge after rst_i deasserts.

Verification
REQ-031 Basic flow: start_i=1, id_ready_i=1, push pc 0x0/0x4/0x8 on consecutive cycles -> id_pc_o 0x0, 0x4, 0x8 one cycle after each push, count_o stays 1.
REQ-032 Fill/full: id_ready_i=0, push 5 entries pc 0x10..0x20 -> stall_o=1 after 4th push, count_o=4, 5th (pc 0x20) dropped; then pop 4 -> id_pc_o 0x10,0x14,0x18,0x1C, count_o=0.
REQ-033 Full with simultaneous push+pop: count_o=4, fetch_valid_i=1, id_ready_i=1 -> count_o=3, incoming entry dropped, stall_o=0 next cycle.
REQ-034 Wrap-around: 10 push/pop pairs with pops lagging by 2 -> order preserved across pointer wrap, id_instr_o matches push order.
REQ-035 Flush: count_o=3, flush_i=1 with fetch_valid_i=1 -> next cycle count_o=0, id_valid_o=0, pushed entry absent.
REQ-036 Async reset: count_o=2, raise rst_i mid-cycle -> id_valid_o=0, id_pc_o=0, count_o=0 before next edge.
